// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Owns the architectural fetch PC, issues in-order
// word reads to instruction memory, and buffers returned instructions (with
// their PC and PC+4) in a small FIFO toward decode. A redirect flushes the
// buffer and marks every in-flight read as stale so its response is dropped.
//
// Parameters:
//   RESET_PC  first PC fetched after reset
//   DEPTH     buffer entries, also the cap on in-flight plus buffered fetches
//             (2..4)
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_redirect_valid/pc   one-cycle redirect request and its target PC
//   o_imem_req/addr       memory read strobe and word-aligned byte address
//   i_imem_rvalid/rdata   in-order memory response
//   o_inst_valid/inst     buffer head toward decode
//   o_inst_pc/pc4         address of the head and that address plus 4
//   i_inst_ready          decode accepts the head this cycle
//   o_misalign            pulses when a redirect target is not word aligned
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic [31:0] o_inst_pc4,
    input  logic        i_inst_ready,
    output logic        o_misalign
);

    // Architectural state. Counters are 3 bits so they can hold DEPTH up to 4.
    logic [31:0] r_pc;
    logic [31:0] r_respPc;
    logic [2:0]  r_outCnt;
    logic [2:0]  r_dropCnt;
    logic [2:0]  r_bufCnt;
    logic [1:0]  r_rdPtr;
    logic [1:0]  r_wrPtr;

    // Storage is sized for the largest legal DEPTH; only DEPTH entries are used.
    logic [31:0] r_instMem [4];
    logic [31:0] r_pcMem   [4];

    logic        w_deq;
    logic        w_enq;
    logic        w_drop;
    logic [3:0]  w_occupancy;
    logic [31:0] w_redirectAligned;
    logic [1:0]  w_rdPtrNext;
    logic [1:0]  w_wrPtrNext;

    // The head handshake feeds straight into the issue decision so a slot freed
    // by decode this cycle can be refilled in the same cycle; that keeps a
    // latency-1 memory streaming one instruction per cycle with only two slots.
    assign w_deq       = o_inst_valid & i_inst_ready;
    assign w_occupancy = {1'b0, r_outCnt} + {1'b0, r_bufCnt} - {3'b000, w_deq};
    assign o_imem_req  = ~i_rst & ~i_redirect_valid & (w_occupancy < 4'(DEPTH));
    assign o_imem_addr = r_pc;

    // A response is discarded while stale responses remain to be consumed, and
    // any response that lands in a redirect cycle is stale as well.
    assign w_drop = i_imem_rvalid & (r_dropCnt != 3'd0);
    assign w_enq  = i_imem_rvalid & (r_dropCnt == 3'd0) & ~i_redirect_valid;

    assign w_redirectAligned = {i_redirect_pc[31:2], 2'b00};
    assign o_misalign        = ~i_rst & i_redirect_valid & (i_redirect_pc[1:0] != 2'b00);

    // Circular pointers wrap at DEPTH, which need not be a power of two.
    assign w_rdPtrNext = (r_rdPtr == 2'(DEPTH - 1)) ? 2'd0 : r_rdPtr + 2'd1;
    assign w_wrPtrNext = (r_wrPtr == 2'(DEPTH - 1)) ? 2'd0 : r_wrPtr + 2'd1;

    // The head is presented straight out of the buffer registers, so it holds
    // steady for as long as decode stalls.
    assign o_inst_valid = (r_bufCnt != 3'd0);
    assign o_inst       = r_instMem[r_rdPtr];
    assign o_inst_pc    = r_pcMem[r_rdPtr];
    assign o_inst_pc4   = r_pcMem[r_rdPtr] + 32'd4;

    // Control state: fetch PC, the PC expected on the next live response,
    // the in-flight/stale counters, and the buffer pointers. Live responses
    // always form a sequential run starting at the last reset or redirect
    // target, so one running PC labels them without storing a PC per request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc      <= RESET_PC;
            r_respPc  <= RESET_PC;
            r_outCnt  <= 3'd0;
            r_dropCnt <= 3'd0;
            r_bufCnt  <= 3'd0;
            r_rdPtr   <= 2'd0;
            r_wrPtr   <= 2'd0;
        end else begin
            r_outCnt <= r_outCnt + {2'b00, o_imem_req} - {2'b00, i_imem_rvalid};
            if (i_redirect_valid) begin
                r_pc     <= w_redirectAligned;
                r_respPc <= w_redirectAligned;
                r_bufCnt <= 3'd0;
                r_rdPtr  <= 2'd0;
                r_wrPtr  <= 2'd0;
                // Every request still outstanding after this cycle is stale.
                // Requests already marked stale are a subset of r_outCnt, so
                // the new stale count is simply what remains in flight.
                r_dropCnt <= r_outCnt - {2'b00, i_imem_rvalid};
            end else begin
                if (o_imem_req) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_enq) begin
                    r_respPc <= r_respPc + 32'd4;
                    r_wrPtr  <= w_wrPtrNext;
                end
                if (w_drop) begin
                    r_dropCnt <= r_dropCnt - 3'd1;
                end
                if (w_deq) begin
                    r_rdPtr <= w_rdPtrNext;
                end
                r_bufCnt <= r_bufCnt + {2'b00, w_enq} - {2'b00, w_deq};
            end
        end
    end

    // Buffer payload has no reset; it is only read while the entry is valid.
    always_ff @(posedge i_clk) begin
        if (w_enq && !i_rst) begin
            r_instMem[r_wrPtr] <= i_imem_rdata;
            r_pcMem[r_wrPtr]   <= r_respPc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Drives fetch_unit against an in-order instruction memory model with
// configurable latency. The reference model thinks in terms of fetch
// "epochs": every reset or redirect starts a new epoch, a response belongs to
// the epoch its request was issued in, and only responses of the current
// epoch reach decode, in address order. Expected instructions are queued when
// a live response is returned; a separate monitor pops and compares them as
// decode accepts them.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        i_clk;
    logic        i_rst;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic [31:0] o_inst_pc4;
    logic        i_inst_ready;
    logic        o_misalign;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_imem_req       (o_imem_req),
        .o_imem_addr      (o_imem_addr),
        .i_imem_rvalid    (i_imem_rvalid),
        .i_imem_rdata     (i_imem_rdata),
        .o_inst_valid     (o_inst_valid),
        .o_inst           (o_inst),
        .o_inst_pc        (o_inst_pc),
        .o_inst_pc4       (o_inst_pc4),
        .i_inst_ready     (i_inst_ready),
        .o_misalign       (o_misalign)
    );

    // Posedges at 5, 15, ...; the bench drives and samples around negedges.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] expPc;
        int          epoch;
        int          due;
    } memReq_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } expInst_t;

    memReq_t  memQ[$];
    expInst_t sbQ[$];

    int          total;
    int          bad;
    int          cycle;
    int          epoch;
    int          latMin;
    int          latMax;
    int          lastDue;
    int          reqCount;
    int          delivered;
    int          firstValidCycle;
    int          relStart;
    logic [31:0] modelPc;
    logic        curRst;
    logic        curRedirect;
    logic        curDeq;
    logic        monArm;
    logic        captureFirst;
    logic [31:0] firstPc;
    logic [31:0] firstPc4;
    logic        monExpValid;

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // One clock cycle of stimulus plus the request/response side of the model.
    task automatic applyStimulus(input logic rst, input logic ready, input logic redir,
                                 input logic [31:0] rpc);
        memReq_t  m;
        expInst_t e;
        logic     expValid;
        logic     expReq;
        int       lat;
        @(negedge i_clk);
        cycle++;
        i_rst            = rst;
        i_inst_ready     = ready;
        i_redirect_valid = redir;
        i_redirect_pc    = rpc;
        if (!rst && memQ.size() > 0 && memQ[0].due <= cycle) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = memWord(memQ[0].addr);
        end else begin
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = $urandom;
        end
        curRst      = rst;
        curRedirect = redir;
        monArm      = 1'b1;
        #1;
        if (rst) begin
            curDeq = 1'b0;
            checkOutput("req_in_reset", {31'd0, o_imem_req}, 32'd0);
            checkOutput("misalign_in_reset", {31'd0, o_misalign}, 32'd0);
            memQ.delete();
            sbQ.delete();
            epoch++;
            modelPc = RESET_PC;
            lastDue = 0;
            #2;
        end else begin
            expValid = (sbQ.size() > 0);
            curDeq   = expValid & ready;
            expReq   = !redir && ((memQ.size() + sbQ.size() - (curDeq ? 1 : 0)) < DEPTH);
            checkOutput("imem_req", {31'd0, o_imem_req}, {31'd0, expReq});
            if (o_imem_req) begin
                checkOutput("imem_addr", o_imem_addr, modelPc);
                reqCount++;
            end
            checkOutput("misalign", {31'd0, o_misalign},
                        {31'd0, (redir && rpc[1:0] != 2'b00)});
            checkOutput("inflight_cap", {31'd0, (memQ.size() <= DEPTH)}, 32'd1);
            #2;
            if (redir) begin
                sbQ.delete();
                epoch++;
                modelPc = {rpc[31:2], 2'b00};
            end
            if (i_imem_rvalid) begin
                m = memQ.pop_front();
                if (m.epoch == epoch) begin
                    e.inst = memWord(m.expPc);
                    e.pc   = m.expPc;
                    sbQ.push_back(e);
                end
            end
            if (o_imem_req) begin
                lat     = $urandom_range(latMax, latMin);
                m.addr  = o_imem_addr;
                m.expPc = modelPc;
                m.epoch = epoch;
                m.due   = (cycle + lat > lastDue + 1) ? cycle + lat : lastDue + 1;
                lastDue = m.due;
                memQ.push_back(m);
                modelPc = modelPc + 32'd4;
            end
        end
    endtask

    // Monitor: compares the buffer head against the expected stream every
    // cycle and retires an entry whenever decode accepts it.
    always @(negedge i_clk) begin
        #2;
        if (monArm && !curRst) begin
            monExpValid = (sbQ.size() > 0);
            checkOutput("inst_valid", {31'd0, o_inst_valid}, {31'd0, monExpValid});
            if (o_inst_valid && firstValidCycle < 0) firstValidCycle = cycle;
            if (monExpValid) begin
                checkOutput("inst", o_inst, sbQ[0].inst);
                checkOutput("inst_pc", o_inst_pc, sbQ[0].pc);
                checkOutput("inst_pc4", o_inst_pc4, sbQ[0].pc + 32'd4);
                if (curDeq && !curRedirect) begin
                    if (captureFirst) begin
                        firstPc      = o_inst_pc;
                        firstPc4     = o_inst_pc4;
                        captureFirst = 1'b0;
                    end
                    void'(sbQ.pop_front());
                    delivered++;
                end
            end
        end
        monArm = 1'b0;
    end

    initial begin
        int d0;
        total = 0; bad = 0; cycle = 0; epoch = 0; lastDue = 0;
        reqCount = 0; delivered = 0; firstValidCycle = -1;
        latMin = 1; latMax = 1; modelPc = RESET_PC;
        curRst = 1'b1; curRedirect = 1'b0; curDeq = 1'b0; monArm = 1'b0;
        captureFirst = 1'b0; firstPc = '0; firstPc4 = '0;
        i_rst = 1'b1; i_redirect_valid = 1'b0; i_redirect_pc = '0;
        i_imem_rvalid = 1'b0; i_imem_rdata = '0; i_inst_ready = 1'b0;

        // Reset, latency-1 memory, decode always ready: first instruction two
        // cycles after reset release, then one per cycle.
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        relStart = cycle + 1;
        firstValidCycle = -1;
        for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 0);
        d0 = delivered;
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0);
        checkOutput("first_valid_cycle", firstValidCycle - relStart, 32'd2);
        checkOutput("stream_rate", delivered - d0, 32'd10);

        // Backpressure: only DEPTH requests while decode stalls, then release.
        applyStimulus(1, 0, 0, 0);
        reqCount = 0;
        captureFirst = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);
        checkOutput("stall_requests", reqCount, 32'd2);
        d0 = delivered;
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0);
        checkOutput("release_first_pc", firstPc, 32'h0);
        checkOutput("release_count", delivered - d0, 32'd3);

        // Latency-3 memory, two reads in flight, redirect to 0x100.
        latMin = 3; latMax = 3;
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        captureFirst = 1'b1;
        applyStimulus(0, 1, 1, 32'h0000_0100);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0);
        checkOutput("redirect_first_pc", firstPc, 32'h0000_0100);

        // Redirect to 0x40 while a response and a dequeue share the cycle.
        latMin = 1; latMax = 1;
        applyStimulus(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0);
        captureFirst = 1'b1;
        applyStimulus(0, 1, 1, 32'h0000_0040);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0);
        checkOutput("redirect40_first_pc", firstPc, 32'h0000_0040);

        // Misaligned redirect target, then wrap past the top of memory.
        applyStimulus(0, 1, 1, 32'h0000_0102);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0);
        captureFirst = 1'b1;
        applyStimulus(0, 1, 1, 32'hFFFF_FFFC);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0);
        checkOutput("wrap_first_pc", firstPc, 32'hFFFF_FFFC);
        checkOutput("wrap_first_pc4", firstPc4, 32'h0000_0000);

        // Reset in the middle of a stream, then refetch from RESET_PC.
        applyStimulus(1, 1, 0, 0);
        captureFirst = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0);
        checkOutput("post_reset_first_pc", firstPc, RESET_PC);

        // Randomized traffic: variable latency, stalls, redirects, resets.
        for (int blk = 0; blk < 8; blk++) begin
            latMin = 1;
            latMax = $urandom_range(4, 1);
            for (int i = 0; i < 200; i++) begin
                applyStimulus(($urandom_range(199, 0) == 0),
                              ($urandom_range(99, 0) < 70),
                              ($urandom_range(99, 0) < 4),
                              {$urandom_range(255, 0), 2'($urandom_range(3, 0))} );
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
